gate_sweep_ctrl: RTL and testbench
==================================

# gate_sweep_ctrl

Sequencer that exhaustively exercises a small combinational gate under test (OR, AND, XOR, …) in hardware. It drives every input vector in ascending order and holds each for a programmable dwell. It samples the gate output at the end of each dwell, builds the observed truth table and compares it against an expected table. It sits beside the gate instance in self-checking builds and replaces hand-written stimulus sequences.

## Interface
- `N_IN`, default 2: number of gate inputs; 1–4 supported; vector count `NV = 2**N_IN`.
- `DWELL`, default 4: cycles each vector is held; minimum 1.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  sweep request; sampled only in IDLE.
- `expected`  in  NV  expected truth table; bit i = gate output for vector i; latched on start.
- `gate_y`  in  1  gate-under-test output.
- `vec_out`  out  N_IN  gate input vector; MSB drives input `a`, LSB drives input `b` (N_IN=2).
- `busy`  out  1  high from accepted start until done.
- `done`  out  1  one-cycle pulse at sweep end.
- `pass`  out  1  observed table equals latched expected; valid from done until next start.
- `table_out`  out  NV  observed truth table.
- `fail_idx`  out  N_IN  lowest mismatching vector index; 0 when pass.

## Operation
- FSM states: IDLE, DRIVE, DONE.
- IDLE with `start`=1 at edge: latch `expected` to `exp_q`, clear `table_out`/`pass`/`fail_idx`, `vec_out`←0, dwell count←0, go to DRIVE.
- DRIVE: dwell count increments each cycle. At the edge where count==DWELL-1:
  - `table_out[vec_out]`←`gate_y`.
  - On the first mismatch against `exp_q[vec_out]`, record `fail_idx`←`vec_out`.
  - If `vec_out`==NV-1, go to DONE; else `vec_out`+1 and count←0.
- DONE: assert `done` for exactly one cycle, set `pass` = (`table_out`==`exp_q`), return to IDLE with `vec_out`←0.
- `start` outside IDLE is ignored; it is not queued.
- Changes to `expected` after acceptance have no effect.
- `vec_out` never wraps past NV-1 within a sweep.
- A `start` held high in IDLE after DONE begins a new sweep immediately.

## Timing
- Reset values:
  - State IDLE.
  - `vec_out`=0, `busy`=0, `done`=0, `pass`=0, `table_out`=0, `fail_idx`=0.
  - Dwell count=0, `exp_q`=0.
- Start accepted at edge k: `busy`=1 and `vec_out`=0 from edge k.
- Sample for vector i happens at edge k+(i+1)·DWELL.
- `done` is high during the cycle after edge k+NV·DWELL. `busy` falls at the same edge.
- Full sweep latency is NV·DWELL cycles, plus 1 cycle DONE.
- Reset mid-sweep: all state returns to reset values asynchronously. No `done` is produced, and the partial table is discarded.
- The gate is combinational. `gate_y` must settle within DWELL cycles; with DWELL=1 it is sampled at the end of the same cycle `vec_out` changes.

## Configuration
- `GATE_SWEEP_EARLY_STOP_EN`:
  - Defined: on the first mismatching sample the FSM goes directly to DONE. `pass`=0, `fail_idx`=that vector, and the unswept `table_out` bits stay 0.
  - Undefined: the full NV-vector sweep always runs. `fail_idx` still reports the lowest mismatch.

## Structure
- `gate_sweep_pkg`: state enum (`SWEEP_IDLE`, `SWEEP_DRIVE`, `SWEEP_DONE`), `NV` derivation function, dwell counter width constant `$clog2(DWELL)` (min 1).
- Sub-module `dwell_timer`:
  - Loadable up-counter.
  - Clear input; `expire` output when count==DWELL-1.
  - Instantiated once.

## Test plan
- OR gate, N_IN=2, DWELL=4, `expected`=4'b1110, pulse start: `vec_out` steps 0,1,2,3 every 4 cycles. `done` pulses 16 cycles after start. `pass`=1, `table_out`=4'b1110, `fail_idx`=0.
- OR gate with `expected`=4'b1000 (AND table): `done` after 16 cycles, `pass`=0, `table_out`=4'b1110, `fail_idx`=1.
- Start re-asserted at cycles 3 and 10 during a sweep: ignored. A single `done` arrives at cycle 16 and `busy` stays 1 throughout.
- Assert `rst` at cycle 9 of a sweep: all outputs 0 immediately, no `done`. A new start then runs a clean 16-cycle sweep.
- DWELL=1, XOR gate, `expected`=4'b0110: `done` 4 cycles after start, `pass`=1. `expected` toggled mid-sweep has no effect.
- With `GATE_SWEEP_EARLY_STOP_EN` defined, OR gate, `expected`=4'b1000: `done` 8 cycles after start, `fail_idx`=1, `table_out`=4'b0010, `pass`=0.

Source files
------------

// File: rtl/gate_sweep_pkg.sv
// Shared types and sizing helpers for the gate_sweep_ctrl truth-table sequencer.
package gate_sweep_pkg;

    typedef enum logic [1:0] {
        SWEEP_IDLE  = 2'd0,
        SWEEP_DRIVE = 2'd1,
        SWEEP_DONE  = 2'd2
    } sweep_state_e;

    function automatic int nv_of(input int n_in);
        return 1 << n_in;
    endfunction

    // A one- or two-cycle dwell still needs a 1-bit counter.
    function automatic int dwell_cnt_w(input int dwell);
        return (dwell > 2) ? $clog2(dwell) : 1;
    endfunction

endpackage

// File: rtl/gate_sweep_ctrl_dwell_timer.sv
// dwell_timer: up-counter that marks the last cycle of each vector's dwell window.
module dwell_timer
    import gate_sweep_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = dwell_cnt_w(DWELL);
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expire = (cnt_q == LAST);

    // Wrap to zero on expiry so the next vector starts a fresh window.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = expire ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl: walks every input vector of a gate under test and builds its truth table.
// Define GATE_SWEEP_EARLY_STOP_EN to end the sweep on the first mismatching sample.
module gate_sweep_ctrl
    import gate_sweep_pkg::*;
#(
    parameter int N_IN  = 2,
    parameter int DWELL = 4,
    localparam int NV   = nv_of(N_IN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [NV-1:0]   expected,
    input  logic            gate_y,
    output logic [N_IN-1:0] vec_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [NV-1:0]   table_out,
    output logic [N_IN-1:0] fail_idx
);

    localparam logic [N_IN-1:0] LAST_VEC = N_IN'(NV - 1);

    sweep_state_e    state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [NV-1:0]   exp_q, exp_d;
    logic [NV-1:0]   table_q, table_d;
    logic            pass_q, pass_d;
    logic [N_IN-1:0] fail_idx_q, fail_idx_d;
    logic            fail_seen_q, fail_seen_d;

    logic tmr_clr, tmr_en, tmr_expire;
    logic sample_bad;

    dwell_timer #(
        .DWELL (DWELL)
    ) u_dwell_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .expire (tmr_expire)
    );

    assign sample_bad = (gate_y != exp_q[vec_q]);

    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        exp_d       = exp_q;
        table_d     = table_q;
        pass_d      = pass_q;
        fail_idx_d  = fail_idx_q;
        fail_seen_d = fail_seen_q;
        tmr_clr     = 1'b1;
        tmr_en      = 1'b0;

        unique case (state_q)
            SWEEP_IDLE: begin
                if (start) begin
                    state_d     = SWEEP_DRIVE;
                    exp_d       = expected;
                    table_d     = '0;
                    pass_d      = 1'b0;
                    fail_idx_d  = '0;
                    fail_seen_d = 1'b0;
                    vec_d       = '0;
                end
            end

            SWEEP_DRIVE: begin
                tmr_clr = 1'b0;
                tmr_en  = 1'b1;
                // Sample on the last cycle of the dwell so the gate has had the full window to settle.
                if (tmr_expire) begin
                    table_d[vec_q] = gate_y;
                    if (sample_bad && !fail_seen_q) begin
                        fail_seen_d = 1'b1;
                        fail_idx_d  = vec_q;
                    end
                    if (vec_q == LAST_VEC) begin
                        state_d = SWEEP_DONE;
                        pass_d  = (table_d == exp_q);
                    end else begin
                        vec_d = vec_q + 1'b1;
                    end
`ifdef GATE_SWEEP_EARLY_STOP_EN
                    if (sample_bad) begin
                        state_d = SWEEP_DONE;
                        vec_d   = vec_q;
                        pass_d  = 1'b0;
                    end
`endif
                end
            end

            SWEEP_DONE: begin
                state_d = SWEEP_IDLE;
                vec_d   = '0;
            end

            default: begin
                state_d = SWEEP_IDLE;
                vec_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SWEEP_IDLE;
            vec_q       <= '0;
            exp_q       <= '0;
            table_q     <= '0;
            pass_q      <= 1'b0;
            fail_idx_q  <= '0;
            fail_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            exp_q       <= exp_d;
            table_q     <= table_d;
            pass_q      <= pass_d;
            fail_idx_q  <= fail_idx_d;
            fail_seen_q <= fail_seen_d;
        end
    end

    assign vec_out   = vec_q;
    assign busy      = (state_q == SWEEP_DRIVE);
    assign done      = (state_q == SWEEP_DONE);
    assign pass      = pass_q;
    assign table_out = table_q;
    assign fail_idx  = fail_idx_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Self-checking bench for gate_sweep_ctrl: one DWELL=4 and one DWELL=1 instance, both N_IN=2.
module tb_gate_sweep_ctrl;

    localparam int NV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       st     [2];
    logic [3:0] ex     [2];
    logic       gy     [2];
    logic [1:0] vec    [2];
    logic       busy   [2];
    logic       done_o [2];
    logic       pass_o [2];
    logic [3:0] tab    [2];
    logic [1:0] fi     [2];
    int         gsel   [2];
    logic [1:0] vsnap  [4];

    int nchk  = 0;
    int npass = 0;

    // Reference model state: when each instance accepted its sweep and what it latched.
    int         ecnt = 0;
    bit         m_act [2];
    int         m_t0  [2];
    logic [3:0] m_exp [2];
    int         m_g   [2];

    always #5 clk = ~clk;

    function automatic int dw_of(input int u);
        return (u == 0) ? 4 : 1;
    endfunction

    // 0 = OR, 1 = AND, otherwise XOR; vector MSB is input a.
    function automatic logic gate_fn(input int g, input logic [1:0] v);
        case (g)
            0:       return v[1] | v[0];
            1:       return v[1] & v[0];
            default: return v[1] ^ v[0];
        endcase
    endfunction

    function automatic int nswept(input logic [3:0] e, input int g);
        bit early = 1'b0;
`ifdef GATE_SWEEP_EARLY_STOP_EN
        early = 1'b1;
`endif
        for (int i = 0; i < NV; i++)
            if (early && (gate_fn(g, 2'(i)) !== e[i])) return i + 1;
        return NV;
    endfunction

    function automatic logic [3:0] tab_after(input int g, input int k);
        logic [3:0] t = '0;
        for (int i = 0; i < k; i++) t[i] = gate_fn(g, 2'(i));
        return t;
    endfunction

    function automatic logic [1:0] fidx_after(input logic [3:0] e, input int g, input int k);
        for (int i = 0; i < k; i++)
            if (gate_fn(g, 2'(i)) !== e[i]) return 2'(i);
        return 2'd0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        nchk++;
        if (act === want) npass++;
        else $display("FAIL %s: got %0d, want %0d", nm, act, want);
    endtask

    assign gy[0] = gate_fn(gsel[0], vec[0]);
    assign gy[1] = gate_fn(gsel[1], vec[1]);

    gate_sweep_ctrl #(.N_IN(2), .DWELL(4)) dut0 (
        .clk(clk), .rst(rst), .start(st[0]), .expected(ex[0]), .gate_y(gy[0]),
        .vec_out(vec[0]), .busy(busy[0]), .done(done_o[0]), .pass(pass_o[0]),
        .table_out(tab[0]), .fail_idx(fi[0])
    );

    gate_sweep_ctrl #(.N_IN(2), .DWELL(1)) dut1 (
        .clk(clk), .rst(rst), .start(st[1]), .expected(ex[1]), .gate_y(gy[1]),
        .vec_out(vec[1]), .busy(busy[1]), .done(done_o[1]), .pass(pass_o[1]),
        .table_out(tab[1]), .fail_idx(fi[1])
    );

    // Model: a start is taken when the previous sweep (if any) has fully ended.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int u = 0; u < 2; u++) m_act[u] <= 1'b0;
        end else begin
            ecnt <= ecnt + 1;
            for (int u = 0; u < 2; u++) begin
                if (st[u] && (!m_act[u] ||
                    (ecnt - m_t0[u]) > nswept(m_exp[u], m_g[u]) * dw_of(u))) begin
                    m_act[u] <= 1'b1;
                    m_t0[u]  <= ecnt + 1;
                    m_exp[u] <= ex[u];
                    m_g[u]   <= gsel[u];
                end
            end
        end
    end

    // Per-cycle compare: outputs follow from edges elapsed since the accepted start.
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            logic       e_busy, e_done, e_pass;
            logic [1:0] e_vec, e_fi;
            logic [3:0] e_tab;
            int         t, ns, len, k;
            e_busy = 1'b0; e_done = 1'b0; e_pass = 1'b0;
            e_vec = '0; e_fi = '0; e_tab = '0;
            if (!rst && m_act[u]) begin
                t   = ecnt - m_t0[u];
                ns  = nswept(m_exp[u], m_g[u]);
                len = ns * dw_of(u);
                k   = t / dw_of(u);
                if (k > ns) k = ns;
                e_tab = tab_after(m_g[u], k);
                e_fi  = fidx_after(m_exp[u], m_g[u], k);
                if (t < len) begin
                    e_busy = 1'b1;
                    e_vec  = 2'(t / dw_of(u));
                end else if (t == len) begin
                    e_done = 1'b1;
                    e_vec  = 2'(ns - 1);
                end
                e_pass = (t >= len) && (e_tab == m_exp[u]);
            end
            chk($sformatf("u%0d busy", u), 32'(busy[u]),   32'(e_busy));
            chk($sformatf("u%0d done", u), 32'(done_o[u]), 32'(e_done));
            chk($sformatf("u%0d pass", u), 32'(pass_o[u]), 32'(e_pass));
            chk($sformatf("u%0d vec", u),  32'(vec[u]),    32'(e_vec));
            chk($sformatf("u%0d tab", u),  32'(tab[u]),    32'(e_tab));
            chk($sformatf("u%0d fidx", u), 32'(fi[u]),     32'(e_fi));
        end
    end

    task automatic sweep(input int u, input logic [3:0] e, input int g,
                         input bit poke, input bit tog, output int lat);
        @(negedge clk);
        ex[u]   = e;
        gsel[u] = g;
        st[u]   = 1'b1;
        @(posedge clk); #1;
        st[u] = 1'b0;
        lat   = -1;
        for (int c = 1; c <= 40 && lat < 0; c++) begin
            @(posedge clk); #1;
            if (u == 0 && c % 4 == 1 && c < 16) vsnap[c / 4] = vec[u];
            if (done_o[u]) lat = c;
            if (poke) st[u] = (c == 3 || c == 10);
            if (tog) ex[u] = ~ex[u];
        end
        st[u] = 1'b0;
    endtask

    task automatic count_done(input int u, input int n, output int cnt);
        cnt = 0;
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            if (done_o[u]) cnt++;
        end
    endtask

    initial begin
        int lat, nd, d1, d2;
        rst = 1'b1;
        st  = '{1'b0, 1'b0};
        ex  = '{4'd0, 4'd0};
        gsel = '{0, 2};
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("reset vec",   32'(vec[0]),    0);
        chk("reset busy",  32'(busy[0]),   0);
        chk("reset done",  32'(done_o[0]), 0);
        chk("reset pass",  32'(pass_o[0]), 0);
        chk("reset tab",   32'(tab[0]),    0);
        chk("reset fidx",  32'(fi[0]),     0);

        // OR gate against its own table.
        sweep(0, 4'b1110, 0, 1'b0, 1'b0, lat);
        chk("or latency", lat, 16);
        chk("or tab",  32'(tab[0]),    32'h0000_000e);
        chk("or pass", 32'(pass_o[0]), 1);
        chk("or fidx", 32'(fi[0]),     0);
        for (int j = 0; j < 4; j++) chk($sformatf("or vec step %0d", j), 32'(vsnap[j]), j);
        repeat (3) @(posedge clk);

        // OR gate against the AND table.
        sweep(0, 4'b1000, 0, 1'b0, 1'b0, lat);
`ifdef GATE_SWEEP_EARLY_STOP_EN
        chk("and latency", lat, 8);
        chk("and tab", 32'(tab[0]), 32'h0000_0002);
`else
        chk("and latency", lat, 16);
        chk("and tab", 32'(tab[0]), 32'h0000_000e);
`endif
        chk("and pass", 32'(pass_o[0]), 0);
        chk("and fidx", 32'(fi[0]),     1);
        repeat (3) @(posedge clk);

        // Starts during the sweep are dropped.
        sweep(0, 4'b1110, 0, 1'b1, 1'b0, lat);
        chk("poke latency", lat, 16);
        chk("poke pass", 32'(pass_o[0]), 1);
        count_done(0, 20, nd);
        chk("poke extra done", nd, 0);

        // Reset in the middle of a sweep.
        @(negedge clk);
        ex[0] = 4'b1110;
        st[0] = 1'b1;
        @(posedge clk); #1;
        st[0] = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("pre-rst busy", 32'(busy[0]), 1);
        chk("pre-rst vec",  32'(vec[0]),  2);
        chk("pre-rst tab",  32'(tab[0]),  32'h0000_0002);
        #2 rst = 1'b1;
        #1;
        chk("rst busy", 32'(busy[0]),   0);
        chk("rst vec",  32'(vec[0]),    0);
        chk("rst tab",  32'(tab[0]),    0);
        chk("rst done", 32'(done_o[0]), 0);
        chk("rst pass", 32'(pass_o[0]), 0);
        chk("rst fidx", 32'(fi[0]),     0);
        @(negedge clk);
        #1 rst = 1'b0;
        count_done(0, 20, nd);
        chk("rst no done", nd, 0);
        sweep(0, 4'b1110, 0, 1'b0, 1'b0, lat);
        chk("post-rst latency", lat, 16);
        chk("post-rst pass", 32'(pass_o[0]), 1);

        // DWELL=1 XOR with expected toggling after acceptance.
        sweep(1, 4'b0110, 2, 1'b0, 1'b1, lat);
        chk("xor latency", lat, 4);
        chk("xor pass", 32'(pass_o[1]), 1);
        chk("xor tab",  32'(tab[1]),    32'h0000_0006);
        repeat (3) @(posedge clk);

        // Start held high: a new sweep begins right after DONE.
        @(negedge clk);
        ex[1] = 4'b0110;
        st[1] = 1'b1;
        d1 = -1;
        d2 = -1;
        for (int c = 1; c <= 40 && d2 < 0; c++) begin
            @(posedge clk); #1;
            if (done_o[1]) begin
                if (d1 < 0) d1 = c;
                else d2 = c;
            end
        end
        st[1] = 1'b0;
        chk("held-start first done", d1, 5);
        chk("held-start spacing", d2 - d1, 6);
        repeat (4) @(posedge clk);

        @(negedge clk);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
